gprs_mp: RTL and testbench
==========================

# gprs_mp

Parametrised multi-port general-purpose register file, the successor to the single-write GPR array in the core. It provides configurable read/write port counts with same-cycle write-to-read bypass and a hard-wired zero register. It also adds a per-register pending-write scoreboard for long-latency producers (load, divide) and a req/ack debug access port serviced only while the core is halted. It sits between decode (reads), writeback (writes) and the debug module.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- NUM_RD, 2, read ports (≥1)
- NUM_WR, 1, write ports (≥1); higher index has priority on same-address collision
- ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes/scoreboard sets

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- i_rd_addr  in  NUM_RD*ADDR_W  read addresses, port k at bits [k*ADDR_W +: ADDR_W]
- o_rd_data  out  NUM_RD*DATA_W  read data, combinational
- o_rd_busy  out  NUM_RD  addressed register has an outstanding pending write
- i_wr_en  in  NUM_WR  write enables
- i_wr_addr  in  NUM_WR*ADDR_W  write addresses
- i_wr_data  in  NUM_WR*DATA_W  write data
- i_sb_set_en  in  1  mark a register pending (long-latency op issued)
- i_sb_set_addr  in  ADDR_W  register to mark
- o_busy_vec  out  2**ADDR_W  registered scoreboard state
- i_dbg_halt  in  1  core halted; debug accesses permitted
- i_dbg_req  in  1  debug access request
- i_dbg_we  in  1  1 = write, 0 = read
- i_dbg_addr  in  ADDR_W  debug register address
- i_dbg_wdata  in  DATA_W  debug write data
- o_dbg_ack  out  1  one-cycle completion pulse
- o_dbg_rdata  out  DATA_W  registered debug read data, valid with ack

## Operation
- Storage: 2**ADDR_W × DATA_W flops; reset clears all registers and all busy bits.
- Write: each enabled port writes its address at the clock edge. On address collision, the highest-index port wins. With ZERO_REG=1, writes to address 0 are dropped.
- Read, per port k, in priority order:
  - 0 if ZERO_REG and address is 0;
  - otherwise the highest-index enabled write port to the same address (bypass);
  - otherwise the array.
- Debug write, when accepted, has priority over all write ports for that cycle and address, and is visible to read bypass that cycle.
- Scoreboard:
  - busy[a] set by i_sb_set_en; cleared by any effective write (port or debug) to a.
  - Set and clear of the same register in the same cycle: set wins.
  - Set to register 0 is ignored when ZERO_REG.
  - o_rd_busy[k] = busy[addr] & ~(an effective write to addr this cycle), consistent with the data bypass.
- Debug FSM states:
  - IDLE: on i_dbg_req & i_dbg_halt, perform the write (if we=1) or sample the bypassed read value into o_dbg_rdata (if we=0), then go to ACK.
  - ACK: o_dbg_ack=1 for exactly one cycle; requests are ignored; return to IDLE.
  - A request with i_dbg_halt=0 waits in IDLE with no effect and no ack.
  - Requester must deassert req after ack; a held req starts a new access in the cycle after ACK.
- o_dbg_rdata holds its value until the next accepted read; debug writes leave it unchanged.

## Timing
- Reads and o_rd_busy: zero-latency combinational from addresses and write inputs.
- Writes and scoreboard updates visible in the array / o_busy_vec after the edge.
- Debug: accept at edge N, ack high during cycle N+1; minimum spacing between accepts is 2 cycles.
- Reset values:
  - o_dbg_ack=0, o_dbg_rdata=0, o_busy_vec=0;
  - o_rd_data=0 for every address unless bypassed;
  - FSM=IDLE.
- rst mid-access (during ACK or with req pending): FSM returns to IDLE, ack is suppressed, and any debug write issued in the reset cycle is discarded.

## Test plan
- Reset, then read all 32 addresses on both ports -> 0; o_busy_vec=0.
- NUM_WR=2: both ports write addr 5 in one cycle (0xAAAA, 0xBBBB) -> same-cycle read of 5 returns 0xBBBB; a later read also returns 0xBBBB. Write 0x1234 to addr 0 -> reads 0.
- i_sb_set addr 7 -> o_busy_vec[7]=1 next cycle. Write addr 7 = 0x55 -> o_rd_busy=0 and data 0x55 in the same cycle; busy bit clear after the edge. Set and write addr 7 in one cycle -> remains busy.
- Debug with halt=0: req held 5 cycles -> no ack. Raise halt -> ack one cycle after acceptance. Write 0xDEAD to x3, then read x3 -> o_dbg_rdata=0xDEAD with ack.
- Debug write to x9 = 0x1 coincident with port write to x9 = 0x2 -> x9=0x1 and same-cycle read returns 0x1.
- Assert rst during ACK -> ack=0 next cycle, FSM idle, all registers 0.

Source files
------------

// File: rtl/gprs_mp.sv
// gprs_mp: multi-port GPR file with write-to-read bypass, hard-wired zero
// register, pending-write scoreboard and a halted-core debug access port.
module gprs_mp #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned NUM_WR   = 1,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_RD*ADDR_W-1:0]   i_rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   o_rd_data,
  output logic [NUM_RD-1:0]          o_rd_busy,
  input  logic [NUM_WR-1:0]          i_wr_en,
  input  logic [NUM_WR*ADDR_W-1:0]   i_wr_addr,
  input  logic [NUM_WR*DATA_W-1:0]   i_wr_data,
  input  logic                       i_sb_set_en,
  input  logic [ADDR_W-1:0]          i_sb_set_addr,
  output logic [(2**ADDR_W)-1:0]     o_busy_vec,
  input  logic                       i_dbg_halt,
  input  logic                       i_dbg_req,
  input  logic                       i_dbg_we,
  input  logic [ADDR_W-1:0]          i_dbg_addr,
  input  logic [DATA_W-1:0]          i_dbg_wdata,
  output logic                       o_dbg_ack,
  output logic [DATA_W-1:0]          o_dbg_rdata
);

  localparam int unsigned DEPTH  = 2**ADDR_W;
  // Read lookups: NUM_RD architectural ports plus one for the debug read.
  localparam int unsigned NUM_LK = NUM_RD + 1;

  typedef enum logic {S_IDLE, S_ACK} state_t;

  state_t                    state;
  logic [DATA_W-1:0]         mem [DEPTH];
  logic [DEPTH-1:0]          busy;
  logic                      dbg_acc;
  logic                      dbg_wr;
  logic [NUM_LK*ADDR_W-1:0]  lk_addr;
  logic [DATA_W-1:0]         lk_data [NUM_LK];

  // Debug access is accepted only from IDLE while halted; a reset cycle discards it.
  assign dbg_acc = (state == S_IDLE) & i_dbg_req & i_dbg_halt & ~rst;
  assign dbg_wr  = dbg_acc & i_dbg_we;
  assign lk_addr = {i_dbg_addr, i_rd_addr};
  assign o_busy_vec = busy;

  for (genvar k = 0; k < NUM_LK; k++) begin : g_lk
    logic [ADDR_W-1:0] a;
    logic              hit;
    logic [DATA_W-1:0] byp;

    assign a = lk_addr[k*ADDR_W +: ADDR_W];

    // Bypass select: later write ports override earlier ones, debug write overrides all, zero reg overrides everything.
    always_comb begin
      hit = 1'b0;
      byp = '0;
      for (int j = 0; j < int'(NUM_WR); j++) begin
        if (i_wr_en[j] && (i_wr_addr[j*ADDR_W +: ADDR_W] == a)) begin
          hit = 1'b1;
          byp = i_wr_data[j*DATA_W +: DATA_W];
        end
      end
      if (dbg_wr && (i_dbg_addr == a)) begin
        hit = 1'b1;
        byp = i_dbg_wdata;
      end
      if (ZERO_REG && (a == '0)) begin
        hit = 1'b1;
        byp = '0;
      end
    end

    assign lk_data[k] = hit ? byp : mem[a];

    if (k < NUM_RD) begin : g_port
      assign o_rd_data[k*DATA_W +: DATA_W] = lk_data[k];
      // A write landing this cycle retires the pending state, matching the bypassed data.
      assign o_rd_busy[k] = busy[a] & ~hit;
    end
  end

  // Register array and scoreboard update; last assignment wins gives port/debug/set priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
      busy <= '0;
    end else begin
      for (int j = 0; j < int'(NUM_WR); j++) begin
        if (i_wr_en[j] && !(ZERO_REG && (i_wr_addr[j*ADDR_W +: ADDR_W] == '0))) begin
          mem[i_wr_addr[j*ADDR_W +: ADDR_W]]  <= i_wr_data[j*DATA_W +: DATA_W];
          busy[i_wr_addr[j*ADDR_W +: ADDR_W]] <= 1'b0;
        end
      end
      if (dbg_wr && !(ZERO_REG && (i_dbg_addr == '0))) begin
        mem[i_dbg_addr]  <= i_dbg_wdata;
        busy[i_dbg_addr] <= 1'b0;
      end
      if (i_sb_set_en && !(ZERO_REG && (i_sb_set_addr == '0))) begin
        busy[i_sb_set_addr] <= 1'b1;
      end
    end
  end

  // Debug handshake FSM: accept in IDLE, pulse ack for one cycle in ACK.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      o_dbg_ack   <= 1'b0;
      o_dbg_rdata <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          o_dbg_ack <= 1'b0;
          if (dbg_acc) begin
            if (!i_dbg_we) begin
              o_dbg_rdata <= lk_data[NUM_RD];
            end
            o_dbg_ack <= 1'b1;
            state     <= S_ACK;
          end
        end
        S_ACK: begin
          o_dbg_ack <= 1'b0;
          state     <= S_IDLE;
        end
        default: begin
          o_dbg_ack <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gprs_mp.sv
// tb_gprs_mp: directed stimulus against a behavioural register-file model.
module tb_gprs_mp;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NR = 2;
  localparam int unsigned NW = 2;
  localparam int unsigned DEPTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]    rd_busy;
  logic [NW-1:0]    wr_en;
  logic [NW*AW-1:0] wr_addr;
  logic [NW*DW-1:0] wr_data;
  logic             sb_set_en;
  logic [AW-1:0]    sb_set_addr;
  logic [DEPTH-1:0] busy_vec;
  logic             dbg_halt, dbg_req, dbg_we, dbg_ack;
  logic [AW-1:0]    dbg_addr;
  logic [DW-1:0]    dbg_wdata, dbg_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model state
  logic [DW-1:0]    m_mem [DEPTH];
  logic [DEPTH-1:0] m_busy;
  logic             m_ack;
  logic [DW-1:0]    m_rdata;
  bit               m_valid = 1'b0;

  gprs_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW), .ZERO_REG(1'b1)) dut (
    .clk(clk), .rst(rst),
    .i_rd_addr(rd_addr), .o_rd_data(rd_data), .o_rd_busy(rd_busy),
    .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .i_sb_set_en(sb_set_en), .i_sb_set_addr(sb_set_addr), .o_busy_vec(busy_vec),
    .i_dbg_halt(dbg_halt), .i_dbg_req(dbg_req), .i_dbg_we(dbg_we),
    .i_dbg_addr(dbg_addr), .i_dbg_wdata(dbg_wdata),
    .o_dbg_ack(dbg_ack), .o_dbg_rdata(dbg_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_dbg_accept();
    return !m_ack && dbg_req && dbg_halt && !rst;
  endfunction

  // Value a read of address a must see this cycle
  function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (m_dbg_accept() && dbg_we && dbg_addr == a) return dbg_wdata;
    for (int j = NW - 1; j >= 0; j--)
      if (wr_en[j] && wr_addr[j*AW +: AW] == a) return wr_data[j*DW +: DW];
    return m_mem[a];
  endfunction

  // Whether address a receives an effective write this cycle
  function automatic bit m_written(input logic [AW-1:0] a);
    if (a == 0) return 1'b0;
    if (m_dbg_accept() && dbg_we && dbg_addr == a) return 1'b1;
    for (int j = 0; j < NW; j++)
      if (wr_en[j] && wr_addr[j*AW +: AW] == a) return 1'b1;
    return 1'b0;
  endfunction

  // Compare every output against the model, then advance the model to the next edge
  always @(negedge clk) begin
    logic [DW-1:0] rv;
    if (m_valid) begin
      for (int k = 0; k < NR; k++) begin
        chk($sformatf("rd_data[%0d]", k), 64'(rd_data[k*DW +: DW]), 64'(m_read(rd_addr[k*AW +: AW])));
        chk($sformatf("rd_busy[%0d]", k), 64'(rd_busy[k]),
            64'(m_busy[rd_addr[k*AW +: AW]] && !m_written(rd_addr[k*AW +: AW])));
      end
      chk("busy_vec", 64'(busy_vec), 64'(m_busy));
      chk("dbg_ack", 64'(dbg_ack), 64'(m_ack));
      chk("dbg_rdata", 64'(dbg_rdata), 64'(m_rdata));
    end
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      m_busy  = '0;
      m_ack   = 1'b0;
      m_rdata = '0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      bit acc;
      acc = m_dbg_accept();
      rv  = m_read(dbg_addr);
      for (int j = 0; j < NW; j++)
        if (wr_en[j] && wr_addr[j*AW +: AW] != 0) begin
          m_mem[wr_addr[j*AW +: AW]]  = wr_data[j*DW +: DW];
          m_busy[wr_addr[j*AW +: AW]] = 1'b0;
        end
      if (acc && dbg_we && dbg_addr != 0) begin
        m_mem[dbg_addr]  = dbg_wdata;
        m_busy[dbg_addr] = 1'b0;
      end
      if (sb_set_en && sb_set_addr != 0) m_busy[sb_set_addr] = 1'b1;
      if (acc && !dbg_we) m_rdata = rv;
      m_ack = acc;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en = '0; wr_addr = '0; wr_data = '0;
    sb_set_en = 1'b0; sb_set_addr = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
  endtask

  initial begin
    rst = 1'b1; rd_addr = '0; dbg_halt = 1'b0;
    idle_inputs();
    step(); step();
    rst = 1'b0;

    // Every address reads zero after reset
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr = {AW'(a), AW'(a)};
      @(negedge clk);
      chk("reset_rd0", 64'(rd_data[DW-1:0]), 64'h0);
      chk("reset_rd1", 64'(rd_data[2*DW-1:DW]), 64'h0);
      step();
    end
    @(negedge clk);
    chk("reset_busy_vec", 64'(busy_vec), 64'h0);
    chk("reset_ack", 64'(dbg_ack), 64'h0);
    step();

    // Two ports collide on addr 5: higher port wins, bypass and array agree
    wr_en = 2'b11; wr_addr = {AW'(5), AW'(5)}; wr_data = {32'hBBBB, 32'hAAAA};
    rd_addr = {AW'(0), AW'(5)};
    @(negedge clk);
    chk("collide_bypass", 64'(rd_data[DW-1:0]), 64'hBBBB);
    step();
    idle_inputs();
    @(negedge clk);
    chk("collide_array", 64'(rd_data[DW-1:0]), 64'hBBBB);
    step();

    // Writes to x0 are dropped
    wr_en = 2'b01; wr_addr = {AW'(0), AW'(0)}; wr_data = {32'h0, 32'h1234};
    rd_addr = {AW'(0), AW'(5)};
    @(negedge clk);
    chk("x0_bypass", 64'(rd_data[2*DW-1:DW]), 64'h0);
    step();
    idle_inputs();
    @(negedge clk);
    chk("x0_array", 64'(rd_data[2*DW-1:DW]), 64'h0);
    step();

    // Scoreboard set, clear by write, set-wins on same-cycle set+write
    sb_set_en = 1'b1; sb_set_addr = 7; rd_addr = {AW'(0), AW'(7)};
    step();
    idle_inputs();
    @(negedge clk);
    chk("sb_set_vec7", 64'(busy_vec[7]), 64'h1);
    chk("sb_set_rdbusy", 64'(rd_busy[0]), 64'h1);
    step();
    wr_en = 2'b01; wr_addr = {AW'(0), AW'(7)}; wr_data = {32'h0, 32'h55};
    @(negedge clk);
    chk("sb_clr_rdbusy", 64'(rd_busy[0]), 64'h0);
    chk("sb_clr_data", 64'(rd_data[DW-1:0]), 64'h55);
    step();
    idle_inputs();
    @(negedge clk);
    chk("sb_clr_vec7", 64'(busy_vec[7]), 64'h0);
    step();
    sb_set_en = 1'b1; sb_set_addr = 7;
    wr_en = 2'b10; wr_addr = {AW'(7), AW'(0)}; wr_data = {32'h66, 32'h0};
    step();
    idle_inputs();
    @(negedge clk);
    chk("sb_setwins_vec7", 64'(busy_vec[7]), 64'h1);
    chk("sb_setwins_data", 64'(rd_data[DW-1:0]), 64'h66);
    step();
    sb_set_en = 1'b1; sb_set_addr = 0;
    step();
    idle_inputs();
    @(negedge clk);
    chk("sb_set_x0", 64'(busy_vec[0]), 64'h0);
    step();

    // Debug requests without halt are ignored
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 3; dbg_wdata = 32'hDEAD;
    rd_addr = {AW'(0), AW'(3)};
    for (int i = 0; i < 5; i++) begin
      step();
      @(negedge clk);
      chk("nohalt_ack", 64'(dbg_ack), 64'h0);
    end
    step();
    dbg_halt = 1'b1;
    step();
    dbg_req = 1'b0;
    @(negedge clk);
    chk("dbgwr_ack", 64'(dbg_ack), 64'h1);
    chk("dbgwr_x3", 64'(rd_data[DW-1:0]), 64'hDEAD);
    step();
    @(negedge clk);
    chk("dbgwr_ack_drop", 64'(dbg_ack), 64'h0);
    step();
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 3;
    step();
    dbg_req = 1'b0;
    @(negedge clk);
    chk("dbgrd_ack", 64'(dbg_ack), 64'h1);
    chk("dbgrd_data", 64'(dbg_rdata), 64'hDEAD);
    step();

    // Debug write beats a port write to the same register
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 9; dbg_wdata = 32'h1;
    wr_en = 2'b01; wr_addr = {AW'(0), AW'(9)}; wr_data = {32'h0, 32'h2};
    rd_addr = {AW'(9), AW'(9)};
    @(negedge clk);
    chk("dbgprio_bypass", 64'(rd_data[DW-1:0]), 64'h1);
    step();
    idle_inputs();
    @(negedge clk);
    chk("dbgprio_array", 64'(rd_data[2*DW-1:DW]), 64'h1);
    step();

    // Held request: back-to-back accesses every second cycle (model checks ack cadence)
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 9;
    repeat (4) step();
    idle_inputs();
    step();

    // Reset while in ACK with a new write request pending
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 12; dbg_wdata = 32'h77;
    step();
    rst = 1'b1; dbg_addr = 13; dbg_wdata = 32'h99;
    @(negedge clk);
    chk("rstack_before", 64'(dbg_ack), 64'h1);
    step();
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    chk("rstack_ack", 64'(dbg_ack), 64'h0);
    chk("rstack_rdata", 64'(dbg_rdata), 64'h0);
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr = {AW'(a), AW'(a)};
      @(negedge clk);
      chk("rstack_regs", 64'(rd_data), 64'h0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
